// File: rtl/dtc_vector_feeder.sv
// dtc_vector_feeder: serial feature-vector assembler and result collector for a decision-tree classifier.
// Define DTC_FEEDER_PARITY_EN to accept a trailing even-parity bit per vector and report mismatches on m_err.
module dtc_vector_feeder #(
    parameter int N_FEAT = 12,
    parameter int N_CLS  = 3,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic              s_bit,
    output logic              s_ready,
    output logic [N_FEAT-1:0] feat_out,
    input  logic [N_CLS-1:0]  cls_in,
    output logic              m_valid,
    output logic [N_CLS-1:0]  m_class,
    output logic              m_err,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  done_cnt
);
    localparam int BW = $clog2(N_FEAT);
    localparam int LW = $clog2(LAT + 1);
    localparam logic [1:0] SHIFT = 2'd0;
    localparam logic [1:0] EVAL  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
`ifdef DTC_FEEDER_PARITY_EN
    localparam logic [1:0] PAR   = 2'd3;
    logic par_q;
`endif
    logic [1:0]        state;
    logic [BW-1:0]     bit_cnt;
    logic [N_FEAT-1:0] sreg;
    logic [N_FEAT-1:0] next_vec;
    logic [LW-1:0]     lat_cnt;
    logic              last;
    assign next_vec = {s_bit, sreg[N_FEAT-1:1]};
    assign last     = bit_cnt == BW'(N_FEAT - 1);
`ifdef DTC_FEEDER_PARITY_EN
    assign s_ready  = (state == SHIFT) || (state == PAR);
`else
    assign s_ready  = state == SHIFT;
    assign m_err    = 1'b0;
`endif

    // The latency counter starts on the edge that updates feat_out, so cls_in is sampled LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            sreg     <= '0;
            lat_cnt  <= '0;
            feat_out <= '0;
            m_valid  <= 1'b0;
            m_class  <= '0;
            done_cnt <= '0;
`ifdef DTC_FEEDER_PARITY_EN
            m_err    <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: if (s_valid) begin
                    sreg <= next_vec;
                    if (last) begin
                        feat_out <= next_vec;
                        bit_cnt  <= '0;
                        lat_cnt  <= LW'(LAT - 1);
`ifdef DTC_FEEDER_PARITY_EN
                        state    <= PAR;
`else
                        state    <= EVAL;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef DTC_FEEDER_PARITY_EN
                PAR: begin
                    lat_cnt <= (lat_cnt == '0) ? '0 : lat_cnt - 1'b1;
                    if (s_valid) begin
                        par_q <= s_bit;
                        state <= EVAL;
                    end
                end
`endif
                EVAL: if (lat_cnt == '0) begin
                    m_class <= cls_in;
                    m_valid <= 1'b1;
`ifdef DTC_FEEDER_PARITY_EN
                    m_err   <= (^feat_out) ^ par_q;
`endif
                    state   <= HOLD;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                HOLD: if (m_ready) begin
                    m_valid  <= 1'b0;
                    done_cnt <= done_cnt + 1'b1;
                    state    <= SHIFT;
                end
                default: state <= SHIFT;
            endcase
        end
    end
endmodule
